rv32_writeback: RTL and testbench

- Writeback stage that drives the register file write port (wb_en, wb_reg, wb_val).
- Merges two result sources: single-cycle ALU results, and load results from the LSU. Load results pass through a small FIFO and are byte/half aligned and extended.
- Exports a per-register pending-load scoreboard so the issue stage can hold instructions whose source registers are not yet written.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/rv32_writeback_if.sv | 39 +++
 rtl/rv32_load_align.sv | 40 ++++
 rtl/rv32_writeback.sv | 133 +++++++++++++
 tb/tb_rv32_writeback.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the writeback slice.
// Holds load funct3 encodings, datapath widths and the load-queue entry layout.
// No logic; imported by the interface, aligner and writeback top.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One queued load response, kept raw; alignment happens at dequeue.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
    logic [XLEN-1:0]   data;
  } lq_entry_t;

endpackage

// File: rtl/rv32_writeback_if.sv
// Writeback stage bundle: ALU result, LSU load response, regfile write port, scoreboard.
// Master side is the pipeline/bench driving results; slave side is the writeback stage.
// LQ_AW sizes the occupancy count (LQ_AW+1 bits).
interface rv32_writeback_if #(parameter int LQ_AW = 2);
  import rv32_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_val;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;
  logic [XLEN-1:0]   ld_data;

  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [XLEN-1:0]   wb_val;

  logic [XLEN-1:0]   busy_vec;
  logic [LQ_AW:0]    lq_count;

  modport master (
    output alu_valid, alu_rd, alu_val,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_data,
    input  ld_ready,
    input  wb_en, wb_reg, wb_val, busy_vec, lq_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_data,
    output ld_ready,
    output wb_en, wb_reg, wb_val, busy_vec, lq_count
  );

endinterface

// File: rtl/rv32_load_align.sv
// Extracts and extends the addressed byte/half of a raw load word per RV32I funct3.
// Latency: purely combinational, zero cycles.
// Backpressure: none; reusable by forwarding paths.
module rv32_load_align
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] val_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and half; halfword ignores addr_lo[0].
  always_comb begin
    byte_sel = raw_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  // Extend according to load type; unused encodings behave as a full word.
  always_comb begin
    val_o = raw_i;
    case (funct3_i)
      F3_LB:   val_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   val_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  val_o = {24'd0, byte_sel};
      F3_LHU:  val_o = {16'd0, half_sel};
      default: val_o = raw_i;
    endcase
  end

endmodule

// File: rtl/rv32_writeback.sv
// Writeback: merges ALU results and queued load results into one registered regfile write port.
// Latency: ALU 1 cycle; load 1 cycle after the push edge when queue empty and ALU idle.
// Backpressure: ALU never stalls (priority); loads stall via ld_ready when the queue is full.
module rv32_writeback
  import rv32_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input logic               clk,
  input logic               rst_n,
  rv32_writeback_if.slave   wb_if
);

  localparam logic [LQ_AW:0] FULL_CNT = (LQ_AW+1)'(LQ_DEPTH);

  lq_entry_t         lq_mem_q [LQ_DEPTH];
  logic [LQ_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LQ_AW:0]    count_q, count_d;

  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]   wb_val_q, wb_val_d;

  logic              push, pop, ld_ready;
  lq_entry_t         head;
  logic [XLEN-1:0]   head_val;
  logic [XLEN-1:0]   busy_vec;
  logic [LQ_AW-1:0]  offs;

  // Ready depends only on occupancy, so a same-cycle pop never frees a slot for a push.
  assign ld_ready = (count_q != FULL_CNT);
  assign push     = wb_if.ld_valid && ld_ready;
  assign pop      = !wb_if.alu_valid && (count_q != '0);
  assign head     = lq_mem_q[rd_ptr_q];

  rv32_load_align u_align (
    .funct3_i  (head.funct3),
    .addr_lo_i (head.addr_lo),
    .raw_i     (head.data),
    .val_o     (head_val)
  );

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue pointers and count; reset discards every queued load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem_q[wr_ptr_q] <= '{rd:      wb_if.ld_rd,
                              funct3:  wb_if.ld_funct3,
                              addr_lo: wb_if.ld_addr_lo,
                              data:    wb_if.ld_data};
    end
  end

  // Write-stage selection: ALU first, else queue head; x0 updates reg/val but never enables.
  always_comb begin
    wb_en_d  = 1'b0;
    wb_reg_d = wb_reg_q;
    wb_val_d = wb_val_q;
    if (wb_if.alu_valid) begin
      wb_en_d  = (wb_if.alu_rd != '0);
      wb_reg_d = wb_if.alu_rd;
      wb_val_d = wb_if.alu_val;
    end else if (pop) begin
      wb_en_d  = (head.rd != '0);
      wb_reg_d = head.rd;
      wb_val_d = head_val;
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q  <= 1'b0;
      wb_reg_q <= '0;
      wb_val_q <= '0;
    end else begin
      wb_en_q  <= wb_en_d;
      wb_reg_q <= wb_reg_d;
      wb_val_q <= wb_val_d;
    end
  end

  // Pending-write scoreboard: occupied queue slots plus an enabled write stage; x0 never busy.
  always_comb begin
    busy_vec = '0;
    offs     = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      offs = LQ_AW'(i) - rd_ptr_q;
      if ({1'b0, offs} < count_q) busy_vec[lq_mem_q[i].rd] = 1'b1;
    end
    if (wb_en_q) busy_vec[wb_reg_q] = 1'b1;
    busy_vec[0] = 1'b0;
  end

  assign wb_if.ld_ready = ld_ready;
  assign wb_if.wb_en    = wb_en_q;
  assign wb_if.wb_reg   = wb_reg_q;
  assign wb_if.wb_val   = wb_val_q;
  assign wb_if.busy_vec = busy_vec;
  assign wb_if.lq_count = count_q;

`ifndef SYNTHESIS
  // Issue must not send an ALU result to a register that still has a write pending.
  always @(posedge clk) begin
    if (rst_n && wb_if.alu_valid && (wb_if.alu_rd != '0))
      assert (!busy_vec[wb_if.alu_rd]);
  end
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
module tb_rv32_writeback;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32_writeback_if #(.LQ_AW(2)) ifc ();

  rv32_writeback #(.LQ_DEPTH(4), .LQ_AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_if (ifc)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] exp;
  } vec_t;

  wr_t         mq[$];    // model load queue (already aligned expectations)
  wr_t         sbq[$];   // scoreboard of expected enabled writes
  logic        m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_val;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[6];
  logic [31:0] ld_dat[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] alo,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (alo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = alo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    v = '0;
    foreach (mq[i]) v[mq[i].rd] = 1'b1;
    if (m_en) v[m_reg] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

  // One clock: predict from the driven inputs, clock, then compare outputs.
  task automatic step(input string nm, output logic acc);
    wr_t ent;
    #1;
    chk({nm, " ld_ready"}, 32'(ifc.ld_ready), 32'(mq.size() < 4));
    acc = ifc.ld_valid && (mq.size() < 4);
    if (ifc.alu_valid) begin
      m_en = (ifc.alu_rd != 0); m_reg = ifc.alu_rd; m_val = ifc.alu_val;
    end else if (mq.size() > 0) begin
      ent = mq.pop_front();
      m_en = (ent.rd != 0); m_reg = ent.rd; m_val = ent.val;
    end else begin
      m_en = 1'b0;
    end
    if (m_en) sbq.push_back('{m_reg, m_val});
    if (acc) mq.push_back('{ifc.ld_rd, ref_align(ifc.ld_funct3, ifc.ld_addr_lo, ifc.ld_data)});
    @(posedge clk);
    #1;
    chk({nm, " wb_en"}, 32'(ifc.wb_en), 32'(m_en));
    if (ifc.wb_en) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s unexpected write: got reg %0d val 0x%08h want none", nm, ifc.wb_reg, ifc.wb_val);
      end else begin
        ent = sbq.pop_front();
        chk({nm, " wb_reg"}, 32'(ifc.wb_reg), 32'(ent.rd));
        chk({nm, " wb_val"}, ifc.wb_val, ent.val);
      end
    end else begin
      chk({nm, " idle wb_reg"}, 32'(ifc.wb_reg), 32'(m_reg));
      chk({nm, " idle wb_val"}, ifc.wb_val, m_val);
    end
    chk({nm, " lq_count"}, 32'(ifc.lq_count), 32'(mq.size()));
    chk({nm, " busy_vec"}, ifc.busy_vec, model_busy());
  endtask

  task automatic idle_inputs();
    ifc.alu_valid = 1'b0; ifc.alu_rd = '0; ifc.alu_val = '0;
    ifc.ld_valid = 1'b0; ifc.ld_rd = '0; ifc.ld_funct3 = '0; ifc.ld_addr_lo = '0; ifc.ld_data = '0;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                          input logic [31:0] d);
    ifc.ld_valid = 1'b1; ifc.ld_rd = rd; ifc.ld_funct3 = f3; ifc.ld_addr_lo = alo; ifc.ld_data = d;
  endtask

  task automatic drain(input string nm);
    logic acc;
    idle_inputs();
    for (int k = 0; k < 20 && (mq.size() > 0 || m_en); k++) step(nm, acc);
    chk({nm, " drained lq_count"}, 32'(ifc.lq_count), 32'd0);
  endtask

  initial begin
    logic acc;
    int   ld_i;

    tbl[0] = '{3'b000, 2'd3, 32'hFFFFFF80};
    tbl[1] = '{3'b100, 2'd1, 32'h0000007F};
    tbl[2] = '{3'b001, 2'd2, 32'hFFFF80FF};
    tbl[3] = '{3'b101, 2'd0, 32'h00007F01};
    tbl[4] = '{3'b010, 2'd0, 32'h80FF7F01};
    tbl[5] = '{3'b110, 2'd2, 32'h80FF7F01};

    m_en = 1'b0; m_reg = '0; m_val = '0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    #3;
    chk("reset wb_en", 32'(ifc.wb_en), 32'd0);
    chk("reset wb_reg", 32'(ifc.wb_reg), 32'd0);
    chk("reset wb_val", ifc.wb_val, 32'd0);
    chk("reset lq_count", 32'(ifc.lq_count), 32'd0);
    chk("reset busy_vec", ifc.busy_vec, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset ld_ready", 32'(ifc.ld_ready), 32'd1);

    // ALU single write, 1-cycle latency
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd5; ifc.alu_val = 32'h12345678;
    step("alu x5", acc);
    chk("alu x5 busy", ifc.busy_vec, 32'h00000020);
    chk("alu x5 val", ifc.wb_val, 32'h12345678);
    idle_inputs();
    step("alu idle", acc);
    chk("alu idle busy", ifc.busy_vec, 32'd0);

    // Table-driven load alignment
    for (int i = 0; i < 6; i++) begin
      drive_ld(5'd7, tbl[i].f3, tbl[i].alo, 32'h80FF7F01);
      step("align push", acc);
      idle_inputs();
      step("align pop", acc);
      chk($sformatf("align vec%0d wb_val", i), ifc.wb_val, tbl[i].exp);
      chk($sformatf("align vec%0d wb_en", i), 32'(ifc.wb_en), 32'd1);
    end
    step("align idle", acc);

    // ALU held for 6 cycles while 5 loads are offered
    foreach (ld_dat[i]) ld_dat[i] = $urandom;
    ld_i = 0;
    for (int c = 0; c < 6; c++) begin
      ifc.alu_valid = 1'b1; ifc.alu_rd = 5'(10 + c); ifc.alu_val = $urandom;
      if (ld_i < 5) drive_ld(5'(20 + ld_i), 3'(c % 6), 2'(c), ld_dat[ld_i]);
      step("hold", acc);
      if (acc) ld_i++;
      if (c == 4) begin
        chk("hold full ld_ready", 32'(ifc.ld_ready), 32'd0);
        chk("hold full lq_count", 32'(ifc.lq_count), 32'd4);
      end
    end
    ifc.alu_valid = 1'b0; ifc.alu_rd = '0;
    for (int k = 0; k < 10 && ld_i < 5; k++) begin
      drive_ld(5'(20 + ld_i), F3_LW, 2'd0, ld_dat[ld_i]);
      step("hold tail", acc);
      if (acc) ld_i++;
    end
    chk("hold all loads accepted", 32'(ld_i), 32'd5);
    drain("hold drain");

    // Simultaneous push and pop at count 2
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd11; ifc.alu_val = 32'hA5A5_0011;
    drive_ld(5'd16, F3_LW, 2'd0, 32'h0000_1616);
    step("pp fill0", acc);
    ifc.alu_rd = 5'd12; ifc.alu_val = 32'hA5A5_0012;
    drive_ld(5'd17, F3_LW, 2'd0, 32'h0000_1717);
    step("pp fill1", acc);
    ifc.alu_valid = 1'b0; ifc.alu_rd = '0;
    drive_ld(5'd18, F3_LBU, 2'd2, 32'h0018_0000);
    step("pp both", acc);
    chk("pp lq_count", 32'(ifc.lq_count), 32'd2);
    chk("pp pushed busy", 32'(ifc.busy_vec[18]), 32'd1);
    idle_inputs();
    step("pp next", acc);
    chk("pp popped cleared", 32'(ifc.busy_vec[16]), 32'd0);
    drain("pp drain");

    // x0 from both sources
    ifc.alu_valid = 1'b1; ifc.alu_rd = 5'd0; ifc.alu_val = 32'hDEAD_BEEF;
    step("x0 alu", acc);
    chk("x0 alu wb_en", 32'(ifc.wb_en), 32'd0);
    idle_inputs();
    drive_ld(5'd0, F3_LW, 2'd0, 32'hCAFE_F00D);
    step("x0 ld push", acc);
    chk("x0 ld count", 32'(ifc.lq_count), 32'd1);
    idle_inputs();
    step("x0 ld pop", acc);
    chk("x0 ld wb_en", 32'(ifc.wb_en), 32'd0);
    chk("x0 ld dequeued", 32'(ifc.lq_count), 32'd0);

    // Reset with 3 loads queued
    for (int c = 0; c < 3; c++) begin
      ifc.alu_valid = 1'b1; ifc.alu_rd = 5'(1 + c); ifc.alu_val = $urandom;
      drive_ld(5'(25 + c), F3_LW, 2'd0, $urandom);
      step("rst fill", acc);
    end
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst lq_count", 32'(ifc.lq_count), 32'd0);
    chk("async rst busy_vec", ifc.busy_vec, 32'd0);
    chk("async rst wb_en", 32'(ifc.wb_en), 32'd0);
    mq.delete(); sbq.delete();
    m_en = 1'b0; m_reg = '0; m_val = '0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step("post rst", acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
